// File: rtl/cu_fsm_intr.sv
`default_nettype none
// ============================================================================
// Module      : cu_fsm_intr
// Description : Multi-cycle control-unit sequencer (FETCH / EXEC / WB / INTR)
//               with edge-triggered, latched interrupt requests serviced at
//               instruction boundaries, lowest channel index first.
// Ports       : CLK        - clock, all state changes on rising edge
//               RST        - synchronous active-high reset
//               opcode     - instruction ir[6:0]
//               func3      - instruction ir[14:12]
//               intr       - interrupt request lines, one per channel
//               mie        - global interrupt enable
//               pcWrite, regWrite, memWE2, memRDEN1, memRDEN2, csr_WE,
//               int_taken  - single-cycle control strobes
//               intr_id    - channel being serviced (0 outside INTR)
//               state      - current state (FETCH=0 EXEC=1 WB=2 INTR=3)
// Revision    : 1.0 - initial release
// ============================================================================
module cu_fsm_intr #(
   parameter int NUM_INTR = 4,
   parameter int MEM_LAT  = 1,
   localparam int c_ID_W  = (NUM_INTR > 1) ? $clog2(NUM_INTR) : 1
) (
   input  logic                CLK,
   input  logic                RST,
   input  logic [6:0]          opcode,
   input  logic [2:0]          func3,
   input  logic [NUM_INTR-1:0] intr,
   input  logic                mie,
   output logic                pcWrite,
   output logic                regWrite,
   output logic                memWE2,
   output logic                memRDEN1,
   output logic                memRDEN2,
   output logic                csr_WE,
   output logic                int_taken,
   output logic [c_ID_W-1:0]   intr_id,
   output logic [1:0]          state
);

   localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
   localparam logic [6:0] c_OP_STORE  = 7'b0100011;
   localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
   localparam logic [6:0] c_OP_LUI    = 7'b0110111;
   localparam logic [6:0] c_OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] c_OP_JAL    = 7'b1101111;
   localparam logic [6:0] c_OP_JALR   = 7'b1100111;
   localparam logic [6:0] c_OP_IMM    = 7'b0010011;
   localparam logic [6:0] c_OP_RG3    = 7'b0110011;
   localparam logic [6:0] c_OP_SYS    = 7'b1110011;

   localparam logic [2:0] c_WAIT_INIT = 3'(MEM_LAT - 1);

   typedef enum logic [1:0] {
      S_FETCH = 2'd0,
      S_EXEC  = 2'd1,
      S_WB    = 2'd2,
      S_INTR  = 2'd3
   } state_t;

   state_t              r_state;
   state_t              w_next_state;
   logic [2:0]          r_wait;
   logic [2:0]          w_wait_next;
   logic [NUM_INTR-1:0] r_intr_prev;
   logic [NUM_INTR-1:0] r_pend;
   logic [NUM_INTR-1:0] w_rise;
   logic [NUM_INTR-1:0] w_pend_seen;
   logic [NUM_INTR-1:0] w_low_mask;
   logic [NUM_INTR-1:0] w_clr;
   logic [c_ID_W-1:0]   w_low_id;
   logic                w_take_intr;

   assign w_rise      = intr & ~r_intr_prev;
   // Edges arriving in the exit cycle itself are honoured, so a request that
   // rises during EXEC is taken at that instruction's boundary.
   assign w_pend_seen = r_pend | w_rise;
   assign w_take_intr = mie & (|w_pend_seen);

   // Lowest-index pending channel; scanning downward lets lower indices win.
   always_comb begin
      w_low_id   = '0;
      w_low_mask = '0;
      for (int i = NUM_INTR - 1; i >= 0; i--) begin
         if (r_pend[i]) begin
            w_low_id   = c_ID_W'(i);
            w_low_mask = NUM_INTR'(1) << i;
         end
      end
   end

   always_comb begin
      w_next_state = r_state;
      w_wait_next  = r_wait;
      w_clr        = '0;
      pcWrite      = 1'b0;
      regWrite     = 1'b0;
      memWE2       = 1'b0;
      memRDEN1     = 1'b0;
      memRDEN2     = 1'b0;
      csr_WE       = 1'b0;
      int_taken    = 1'b0;
      intr_id      = '0;

      case (r_state)
         S_FETCH: begin
            memRDEN1     = 1'b1;
            w_next_state = S_EXEC;
         end

         S_EXEC: begin
            if (opcode == c_OP_LOAD) begin
               memRDEN2     = 1'b1;
               w_wait_next  = c_WAIT_INIT;
               w_next_state = S_WB;
            end else begin
               pcWrite = 1'b1;
               case (opcode)
                  c_OP_STORE: memWE2 = 1'b1;
                  c_OP_LUI, c_OP_AUIPC, c_OP_JAL, c_OP_JALR,
                  c_OP_IMM, c_OP_RG3: regWrite = 1'b1;
                  c_OP_SYS: begin
                     // func3 == 000 is mret; everything else is a CSR access
                     if (func3 != 3'b000) begin
                        regWrite = 1'b1;
                        csr_WE   = 1'b1;
                     end
                  end
                  default: ;
               endcase
               w_next_state = w_take_intr ? S_INTR : S_FETCH;
            end
         end

         S_WB: begin
            if (r_wait != 3'd0) begin
               w_wait_next = r_wait - 3'd1;
            end else begin
               regWrite     = 1'b1;
               pcWrite      = 1'b1;
               w_next_state = w_take_intr ? S_INTR : S_FETCH;
            end
         end

         S_INTR: begin
            int_taken    = 1'b1;
            pcWrite      = 1'b1;
            intr_id      = w_low_id;
            w_clr        = w_low_mask;
            w_next_state = S_FETCH;
         end

         default: w_next_state = S_FETCH;
      endcase

      if (RST) begin
         pcWrite   = 1'b0;
         regWrite  = 1'b0;
         memWE2    = 1'b0;
         memRDEN1  = 1'b0;
         memRDEN2  = 1'b0;
         csr_WE    = 1'b0;
         int_taken = 1'b0;
         intr_id   = '0;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state     <= S_FETCH;
         r_wait      <= 3'd0;
         r_pend      <= '0;
         r_intr_prev <= '0;
      end else begin
         r_state     <= w_next_state;
         r_wait      <= w_wait_next;
         // Set is OR-ed after the clear so a fresh edge on the serviced
         // channel survives its own clear.
         r_pend      <= (r_pend & ~w_clr) | w_rise;
         r_intr_prev <= intr;
      end
   end

   assign state = r_state;

endmodule
`default_nettype wire

// File: doc/cu_fsm_intr.md
CU_FSM_INTR -- requirements
Module: cu_fsm_intr

Interface
REQ-001 SHALL provide parameter NUM_INTR, default 4, number of interrupt request channels (range 1..16).
REQ-002 SHALL provide parameter MEM_LAT, default 1, number of wait cycles a load spends in WRITEBACK (range 1..7).
REQ-003 SHALL have port CLK  input  1  the single clock; all state updates occur on its rising edge.
REQ-004 SHALL have port RST  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port opcode  input  7  instruction ir[6:0].
REQ-006 SHALL have port func3  input  3  instruction ir[14:12].
REQ-007 SHALL have port intr  input  NUM_INTR  interrupt request lines, one per channel.
REQ-008 SHALL have port mie  input  1  global interrupt enable from the CSR file.
REQ-009 SHALL have outputs pcWrite, regWrite, memWE2, memRDEN1, memRDEN2, csr_WE, int_taken; each output 1, each a strobe.
REQ-010 SHALL have port intr_id  output  max(1,clog2(NUM_INTR))  index of the channel being serviced.
REQ-011 SHALL have port state  output  2  current state (FETCH=0, EXEC=1, WB=2, INTR=3).

Function
REQ-012 SHALL implement four states, FETCH, EXEC, WB and INTR, with all strobes decoded from the current state and current inputs only (Moore/Mealy mix, no registered strobes).
REQ-013 FETCH SHALL assert memRDEN1 only, and the next state SHALL be EXEC.
REQ-014 EXEC with LOAD (0000011) SHALL assert memRDEN2 only, and the next state SHALL be WB.
REQ-015 EXEC with STORE (0100011) SHALL assert memWE2 and pcWrite.
REQ-016 EXEC with BRANCH (1100011) SHALL assert pcWrite only.
REQ-017 EXEC with LUI, AUIPC, JAL, JALR, OP_IMM or OP_RG3 SHALL assert pcWrite and regWrite.
REQ-018 EXEC with SYS (1110011) and func3=000 (mret) SHALL assert pcWrite only.
REQ-019 EXEC with SYS and func3 != 000 (csr op) SHALL assert pcWrite, regWrite and csr_WE.
REQ-020 EXEC with any other opcode SHALL assert pcWrite only (treated as NOP).
REQ-021 On entry to WB, a wait counter SHALL be loaded with MEM_LAT-1; WB SHALL decrement it each cycle and remain in WB while it is nonzero.
REQ-022 WB SHALL assert regWrite and pcWrite only in the cycle the counter is 0, so a load occupies exactly MEM_LAT WB cycles.
REQ-023 For each channel i, the block SHALL register intr[i] each cycle and set pend[i] on a 0->1 transition (rising edge); level-held requests SHALL NOT re-trigger.
REQ-024 Exit from EXEC (non-load) or from the final WB cycle SHALL go to INTR if mie=1 and any pend bit is set, else to FETCH.
REQ-025 If mie=0, pend bits SHALL remain latched and SHALL be serviced on the first eligible exit after mie returns to 1.
REQ-026 INTR SHALL assert int_taken and pcWrite, drive intr_id with the lowest-index set pend bit, clear that bit, and go to FETCH; other pending bits SHALL be retained.
REQ-027 If a new rising edge on the channel being cleared occurs in the same cycle as its clear, set SHALL win.
REQ-028 Outside INTR, intr_id SHALL read 0.
REQ-029 Edges arriving while in INTR SHALL be latched and evaluated at the next EXEC/WB exit; INTR SHALL never chain directly to INTR.

Reset
REQ-030 With RST=1 at a rising edge, the next state SHALL be FETCH, all pend bits and the intr-history register SHALL be 0, and the wait counter SHALL be 0, regardless of current state (including mid-WB or INTR).
REQ-031 While RST=1, all strobes and intr_id SHALL be 0, and state SHALL read 0 from the cycle after the reset edge.

Verification
REQ-032 Reset, then opcode=0110011 -> state sequence 0,1,0; memRDEN1=1 in FETCH; regWrite=1 and pcWrite=1 in EXEC.
REQ-033 With MEM_LAT=3 and opcode=0000011 -> states 0,1,2,2,2,0; memRDEN2=1 in EXEC; regWrite=1 only in the third WB cycle.
REQ-034 With NUM_INTR=4 and mie=1, pulse intr=4'b1010 during EXEC of an ADD -> INTR with intr_id=1, then the next instruction's exit -> INTR with intr_id=3.
REQ-035 With mie=0 and an intr[0] pulse -> no INTR across 3 instructions; then set mie=1 -> INTR with intr_id=0 after the next EXEC.
REQ-036 Hold intr[2]=1 continuously -> exactly one INTR (intr_id=2); drop it and re-raise -> a second INTR.
REQ-037 Assert RST during the second WB cycle of a MEM_LAT=3 load with pend=4'b0001 -> next state FETCH, no regWrite, and no INTR after the following instruction.
